// File: rtl/gray_seq_counter.sv
// Modulo-MODULUS up/down counter with registered binary and reflected-Gray outputs.
// An IDLE->RUN start-up edge precedes counting; clr/load act in either state.
module gray_seq_counter #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 5,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             active
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int               WX    = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_X = WX'(MODULUS);
  localparam logic [WIDTH:0]   ONE_X = WX'(1);
  localparam logic [WIDTH-1:0] MAX_B = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
  logic             wrap_q, wrap_d, active_q, active_d;
  logic [WIDTH:0]   step_x;
  logic             wrapped;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    // One extra bit: up-wrap shows as step == MODULUS, down-wrap as the borrow bit.
    step_x  = up ? ({1'b0, bin_q} + ONE_X) : ({1'b0, bin_q} - ONE_X);
    wrapped = up ? (step_x == MOD_X) : step_x[WIDTH];
    if (clr) begin
      bin_d = RST_B;
    end else if (load) begin
      bin_d = ({1'b0, load_val} < MOD_X) ? load_val : MAX_B;
    end else if (en) begin
      if (state_q == IDLE) begin
        state_d = RUN;
      end else begin
        wrap_d = wrapped;
        bin_d  = wrapped ? (up ? '0 : MAX_B) : step_x[WIDTH-1:0];
      end
    end
    gray_d   = bin_d ^ (bin_d >> 1);
    active_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bin_q    <= RST_B;
      gray_q   <= RST_G;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
    end
  end

  assign bin    = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign active = active_q;
endmodule

// File: doc/gray_seq_counter.md
Name: gray_seq_counter

Overview:
- Parametrised modulo-N sequence counter. Holds a binary count and drives a registered reflected-Gray encoding of it.
- Supports enable, up/down direction, synchronous clear, synchronous load and a wrap pulse.
- Successor to the fixed 3-bit 0..4 sequencer. Used as a pointer/phase generator for downstream FSMs and clock-domain-crossing pointers.

Parameters:
- WIDTH, 3: bit width of count and Gray outputs; legal range 2..16.
- MODULUS, 5: sequence length; count runs 0..MODULUS-1; legal range 2..2**WIDTH.
- RESET_VAL, 0: binary value loaded on reset and on clr; must be < MODULUS.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: count enable, sampled at posedge.
- up, input, 1: direction; 1 = increment, 0 = decrement.
- clr, input, 1: synchronous clear to RESET_VAL.
- load, input, 1: synchronous load of load_val.
- load_val, input, WIDTH: binary load value.
- bin, output, WIDTH: registered binary count.
- gray, output, WIDTH: registered Gray code, equal to bin ^ (bin >> 1).
- wrap, output, 1: one-cycle pulse on the cycle the count wrapped.
- active, output, 1: high once the FSM is in RUN.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; bin = RESET_VAL; gray = Gray(RESET_VAL); wrap = 0; active = 0.
- FSM has two states:
  - IDLE: counter holds its value; active = 0. The first posedge with en = 1 moves the FSM to RUN. The count does not change on that edge; this is a one-cycle start-up latency, as the predecessor had.
  - RUN: active = 1. The FSM stays in RUN until reset. clr returns the count to RESET_VAL but does not return the FSM to IDLE.
- Per-posedge priority in RUN is clr > load > en > hold.
  - clr: bin = RESET_VAL; wrap = 0.
  - load: bin = load_val if load_val < MODULUS, otherwise bin = MODULUS-1 (clamped); wrap = 0.
  - en with up = 1: bin = (bin == MODULUS-1) ? 0 : bin + 1. wrap = 1 on the cycle after the MODULUS-1 -> 0 transition.
  - en with up = 0: bin = (bin == 0) ? MODULUS-1 : bin - 1. wrap = 1 on the cycle after the 0 -> MODULUS-1 transition.
  - no en: hold value; wrap = 0.
- clr and load are also honoured in IDLE. Either one updates bin and gray but does not start the FSM.
- Timing:
  - All outputs are registered.
  - gray updates on the same edge as bin.
  - No combinational path from inputs to outputs.
  - wrap is high for exactly one cycle per wrap event.
- Arithmetic: next-count calculation uses WIDTH+1 bits internally; no silent overflow is possible for MODULUS = 2**WIDTH.
- Single-bit-change property of gray:
  - Guaranteed between all consecutive steps when MODULUS is a power of two.
  - For other moduli, it is guaranteed except across the wrap step.
  - It is not guaranteed across load or clr.
- Direction may change on any cycle. The step uses the up value sampled on that edge.
- If reset asserts mid-sequence, all outputs go to reset values immediately. After release, the block needs a new en edge to re-enter RUN.

Test Plan:
- Defaults (WIDTH = 3, MODULUS = 5), release reset, en = 1, up = 1:
  - bin sequence 0,0,1,2,3,4,0,1 (first 0 is the IDLE -> RUN start-up cycle).
  - gray sequence 000,000,001,011,010,110,000.
  - wrap high only on the cycle bin returns to 0.
  - active rises one cycle after the first en.
- Down count from bin = 1, up = 0, en = 1: bin 1 -> 0 -> 4 -> 3; wrap pulses on the 0 -> 4 step.
- Load and priority:
  - load = 1 with load_val = 3: bin = 3, gray = 010.
  - load_val = 7: bin clamps to 4.
  - clr = 1 and load = 1 together: bin = 0.
  - en = 1 with load = 1: load wins.
- WIDTH = 4, MODULUS = 16, up count over 32 cycles: every consecutive gray pair differs in exactly one bit, including the 15 -> 0 wrap (1000 -> 0000).
- Assert reset low mid-count at bin = 3, asynchronously between edges:
  - bin = 0, gray = 000, active = 0 immediately, with no clock needed.
  - After release, the count stays at 0 until one en cycle restarts it.
- en = 0 for 4 cycles in RUN at bin = 2: bin stays 2 and wrap stays 0. Toggling up while en = 0 has no effect.
